reg_file_2r1w: RTL and testbench

//  32-entry register file with two read ports and one write port, for the single-cycle SOC datapath.

---
 rtl/reg_file_2r1w.sv | 111 +++++++++++
 tb/tb_reg_file_2r1w.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32-entry, two-read / one-write register file for the
// single-cycle datapath. Register 0 reads as zero and is never written.
// Same-cycle write-through bypass on the read ports. A registered debug
// port and write statistics go to the board display.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] last_wa,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic [ADDR_W-1:0] last_wa_q, last_wa_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              commit;

  // A write commits only when enabled and aimed at a real register (not r0).
  always_comb begin
    commit = we && (wa != '0);
  end

  // Next array contents: update the addressed entry and keep r0 pinned at zero.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wa] = wd;
    end
    regs_d[0] = '0;
  end

  // Write statistics: the last committed address and a saturating commit count.
  always_comb begin
    last_wa_d = last_wa_q;
    wr_cnt_d  = wr_cnt_q;
    if (commit) begin
      last_wa_d = wa;
      if (wr_cnt_q != {CNT_W{1'b1}}) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // The debug read samples the stored array with no bypass.
  // On the edge that commits the same address, the pre-write value is captured.
  always_comb begin
    dbg_data_d = '0;
    if (dbg_addr != '0) begin
      dbg_data_d = regs_q[dbg_addr];
    end
  end

  // Read ports: r0 gives zero. A matching in-flight write is bypassed.
  // Otherwise the stored value is returned.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (we && (wa == ra1)) begin
        rd1 = wd;
      end else begin
        rd1 = regs_q[ra1];
      end
    end
    rd2 = '0;
    if (ra2 != '0) begin
      if (we && (wa == ra2)) begin
        rd2 = wd;
      end else begin
        rd2 = regs_q[ra2];
      end
    end
  end

  // State registers. Asynchronous reset clears the array and all outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q <= '0;
      last_wa_q  <= '0;
      wr_cnt_q   <= '0;
    end else begin
      regs_q     <= regs_d;
      dbg_data_q <= dbg_data_d;
      last_wa_q  <= last_wa_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign dbg_data = dbg_data_q;
  assign last_wa  = last_wa_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w (built with CNT_W=4 so saturation is reachable).
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] last_wa;
  logic [CNT_W-1:0]  wr_cnt;

  int errors;
  int checks;

  reg_file_2r1w #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .last_wa (last_wa),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One committed write: drive after a negedge, hold through the posedge, then drop we.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = ADDR_W'(i);
      ra2 = ADDR_W'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1 addr=%0d got=%h exp=0", i, rd1);
      end
      checks++;
      if (rd2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - i, rd2);
      end
    end
    checks++;
    if (wr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd0) begin
      errors++;
      $display("FAIL reset_last_wa got=%0d exp=0", last_wa);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_dbg_data got=%h exp=0", dbg_data);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    ra1 = 5'd5;
    ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd1 got=%h exp=deadbeef", rd1);
    end
    checks++;
    if (rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd2_same_addr got=%h exp=deadbeef", rd2);
    end
    checks++;
    if (wr_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wr_cnt_1 got=%0d exp=1", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd5) begin
      errors++;
      $display("FAIL wr_last_wa_5 got=%0d exp=5", last_wa);
    end
    do_write(5'd31, 32'hA5A5_5A5A);
    ra1 = 5'd31;
    ra2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL wr_rd1_r31 got=%h exp=a5a55a5a", rd1);
    end
    checks++;
    if (rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd2_r5_kept got=%h exp=deadbeef", rd2);
    end
    checks++;
    if (wr_cnt !== 4'd2) begin
      errors++;
      $display("FAIL wr_cnt_2 got=%0d exp=2", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd31) begin
      errors++;
      $display("FAIL wr_last_wa_31 got=%0d exp=31", last_wa);
    end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    we  = 1'b1;
    wa  = 5'd0;
    wd  = 32'hFFFF_FFFF;
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reg0_no_bypass got=%h exp=0", rd1);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reg0_after_edge got=%h exp=0", rd2);
    end
    checks++;
    if (wr_cnt !== 4'd2) begin
      errors++;
      $display("FAIL reg0_wr_cnt got=%0d exp=2", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd31) begin
      errors++;
      $display("FAIL reg0_last_wa got=%0d exp=31", last_wa);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    ra1 = 5'd7;
    ra2 = 5'd7;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL byp_pre_empty got=%h exp=0", rd1);
    end
    we = 1'b1;
    wa = 5'd7;
    wd = 32'h1234_5678;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL byp_rd1 got=%h exp=12345678", rd1);
    end
    checks++;
    if (rd2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL byp_rd2 got=%h exp=12345678", rd2);
    end
    ra2 = 5'd5;
    #1;
    checks++;
    if (rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL byp_other_port got=%h exp=deadbeef", rd2);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL byp_stored got=%h exp=12345678", rd1);
    end
    checks++;
    if (wr_cnt !== 4'd3) begin
      errors++;
      $display("FAIL byp_wr_cnt got=%0d exp=3", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd7) begin
      errors++;
      $display("FAIL byp_last_wa got=%0d exp=7", last_wa);
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd3, 32'h1);
    ra1 = 5'd3;
    #1;
    checks++;
    if (rd1 !== 32'h1) begin
      errors++;
      $display("FAIL arst_pre got=%h exp=1", rd1);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL arst_immediate got=%h exp=0", rd1);
    end
    checks++;
    if (wr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL arst_wr_cnt got=%0d exp=0", wr_cnt);
    end
    checks++;
    if (last_wa !== 5'd0) begin
      errors++;
      $display("FAIL arst_last_wa got=%0d exp=0", last_wa);
    end
    we = 1'b1;
    wa = 5'd3;
    wd = 32'h55;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL arst_no_commit got=%h exp=0", rd1);
    end
    checks++;
    if (wr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL arst_no_count got=%0d exp=0", wr_cnt);
    end
  endtask

  task automatic test_saturation_debug();
    logic [DATA_W-1:0] exp_dbg;
    logic [CNT_W-1:0]  exp_cnt;
    @(negedge clk);
    dbg_addr = 5'd1;
    for (int k = 0; k < 20; k++) begin
      exp_dbg = (k == 0) ? 32'h0 : DATA_W'(100 + k - 1);
      exp_cnt = (k + 1 >= 15) ? 4'd15 : CNT_W'(k + 1);
      do_write(5'd1, DATA_W'(100 + k));
      checks++;
      if (dbg_data !== exp_dbg) begin
        errors++;
        $display("FAIL sat_dbg_lag k=%0d got=%0d exp=%0d", k, dbg_data, exp_dbg);
      end
      checks++;
      if (wr_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL sat_wr_cnt k=%0d got=%0d exp=%0d", k, wr_cnt, exp_cnt);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbg_data !== 32'd119) begin
      errors++;
      $display("FAIL sat_dbg_final got=%0d exp=119", dbg_data);
    end
    checks++;
    if (last_wa !== 5'd1) begin
      errors++;
      $display("FAIL sat_last_wa got=%0d exp=1", last_wa);
    end
    dbg_addr = 5'd0;
    @(posedge clk);
    #1;
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL dbg_addr0 got=%h exp=0", dbg_data);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    ra1      = '0;
    ra2      = '0;
    dbg_addr = '0;
    test_reset();
    test_write_read();
    test_reg0();
    test_bypass();
    test_async_reset();
    test_saturation_debug();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
